clock_step_ctrl: RTL

Generates the SAP-1 CPU clock enable from operator controls. It consumes the debounced, active-low step button and the run/step mode switch. It emits single-cycle `cpu_ce` pulses:
- run mode: one pulse per divided period.
- step mode: one pulse per button press.

It sits between the button debouncers and the CPU core. It honours the CPU halt line and counts issued CPU cycles for the display.

---
 rtl/clock_step_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: SAP-1 CPU clock-enable generator driven by operator controls.
//   Run mode issues one cpu_ce pulse every DIV_MAX+1 clocks. Step mode issues
//   one pulse per press of the debounced step button.
//   Optional feature macro: CLK_STEP_AUTOREPEAT_EN (auto-repeat while the button is held).
// Ports:
//   clk         : FPGA clock
//   rst_n       : asynchronous active-low reset
//   step_n      : debounced step button, active-low, synchronous to clk
//   mode_run    : 1 = run mode, 0 = step mode
//   hlt         : CPU halt request, active-high
//   cpu_ce      : registered single-cycle CPU clock enable
//   halted      : registered sticky halt flag, cleared only by reset
//   cycle_count : number of cpu_ce pulses issued, wraps at 16 bits
module clock_step_ctrl #(
    parameter int DIV_WIDTH    = 16,
    parameter int DIV_MAX      = 49999,
    parameter int REPEAT_DELAY = 24999999,
    parameter int REPEAT_RATE  = 4999999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_n,
    input  logic        mode_run,
    input  logic        hlt,
    output logic        cpu_ce,
    output logic        halted,
    output logic [15:0] cycle_count
);
    localparam logic [1:0] STEP_IDLE = 2'd0;
    localparam logic [1:0] STEP_HELD = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;
    localparam logic [1:0] HALT      = 2'd3;
    localparam logic [DIV_WIDTH-1:0] DIV_END = DIV_WIDTH'(DIV_MAX);
    logic                 s1_q, s2_q;
    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 ce_q, ce_d;
    logic                 halted_q;
    logic [15:0]          cnt_q;
    logic                 press;
`ifdef CLK_STEP_AUTOREPEAT_EN
    // Down-counter: reaching 0 while held issues a repeat pulse.
    logic [31:0]          rep_q, rep_d;
`endif
    assign press       = s2_q & ~s1_q;
    assign cpu_ce      = ce_q;
    assign halted      = halted_q;
    assign cycle_count = cnt_q;
    // hlt overrides everything; mode changes override pulses.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ce_d    = 1'b0;
`ifdef CLK_STEP_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        if (hlt) begin
            state_d = HALT;
            div_d   = '0;
`ifdef CLK_STEP_AUTOREPEAT_EN
            rep_d   = '0;
`endif
        end else begin
            case (state_q)
                STEP_IDLE: begin
                    if (mode_run) begin
                        state_d = RUN;
                        div_d   = '0;
                    end else if (press) begin
                        ce_d    = 1'b1;
                        state_d = STEP_HELD;
`ifdef CLK_STEP_AUTOREPEAT_EN
                        rep_d   = 32'(REPEAT_DELAY - 1);
`endif
                    end
                end
                STEP_HELD: begin
                    if (mode_run) begin
                        state_d = RUN;
                        div_d   = '0;
`ifdef CLK_STEP_AUTOREPEAT_EN
                        rep_d   = '0;
`endif
                    end else if (s1_q) begin
                        state_d = STEP_IDLE;
`ifdef CLK_STEP_AUTOREPEAT_EN
                        rep_d   = '0;
                    end else if (rep_q == '0) begin
                        ce_d    = 1'b1;
                        rep_d   = 32'(REPEAT_RATE - 1);
                    end else begin
                        rep_d   = rep_q - 32'd1;
`endif
                    end
                end
                RUN: begin
                    if (!mode_run) begin
                        state_d = STEP_IDLE;
                        div_d   = '0;
                    end else if (div_q == DIV_END) begin
                        div_d   = '0;
                        ce_d    = 1'b1;
                    end else begin
                        div_d   = div_q + 1'b1;
                    end
                end
                default: div_d = '0;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            state_q  <= STEP_IDLE;
            div_q    <= '0;
            ce_q     <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
`ifdef CLK_STEP_AUTOREPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            s1_q     <= step_n;
            s2_q     <= s1_q;
            state_q  <= state_d;
            div_q    <= div_d;
            ce_q     <= ce_d;
            halted_q <= (state_d == HALT);
            cnt_q    <= cnt_q + {15'd0, ce_d};
`ifdef CLK_STEP_AUTOREPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end
endmodule
